sprite_motion_sched: RTL and testbench
======================================

// Module: sprite_motion_sched
// PURPOSE
//  Per-frame motion scheduler for the letter-sprite overlay. On each VSync falling edge it runs
//  one update pass over N_SPR sprite boxes through a single shared step/bounce unit, one sprite per
//  enabled cycle. It manages GROUP/SPLIT/REGROUP modes and publishes all positions atomically.
//  The overlay renderer consumes pos_x_o/pos_y_o; sprite widths/heights are fixed by parameters.
// PARAMETERS
//  N_SPR     4                          number of sprites (2..8)
//  SPR_W     200                        sprite box width, pixels
//  SPR_H     250                        sprite box height, pixels
//  X_MAX     1920                       active width
//  Y_MAX     1080                       active height
//  HOME_X    {12'd1350,12'd850+250,12'd850,12'd600}  packed home x per sprite, ascending, [12*i+:12]
//  HOME_Y    {4{12'd450}}               packed home y per sprite (all equal)
//  SPLIT_DIR 8'b11_01_00_10             per sprite {ydir,xdir} on SPLIT entry, 1 = increasing
// PORTS
//  clk_i        in   1          clock
//  rst_i        in   1          synchronous active-high reset
//  cen_i        in   1          clock enable; all state holds when low
//  fvht_i       in   4          video timing; bit 2 = VSync
//  split_i      in   1          1 = split sprites, 0 = group/regroup
//  speed_i      in   4          pixels per frame, 0 = freeze
//  pos_x_o      out  12*N_SPR   committed x (left edge) per sprite
//  pos_y_o      out  12*N_SPR   committed y (top edge) per sprite
//  mode_o       out  2          0 GROUP, 1 SPLIT, 2 REGROUP (committed)
//  busy_o       out  1          pass in progress
//  frame_done_o out  1          one enabled-cycle pulse when outputs commit
//  overrun_o    out  1          sticky: tick arrived while busy
// BEHAVIOUR
//  Reset: working+committed pos = HOME_X/HOME_Y, mode GROUP, group dirs +x,+y, FSM IDLE, busy_o 0,
//   frame_done_o 0, overrun_o 0, VSync delay reg 0. Reset mid-pass abandons the pass.
//  Tick = enabled cycle with fvht_i[2]==0 and registered previous VSync==1.
//  FSM: IDLE -tick-> PREP -> UPDATE (idx 0..N_SPR-1, one per enabled cycle) -> COMMIT -> IDLE.
//  Latency: tick at enabled edge 0; outputs + frame_done_o change at enabled edge N_SPR+2.
//  busy_o high in PREP/UPDATE/COMMIT. Tick while not IDLE: ignored, overrun_o <= 1 until reset.
//  PREP: sample split_i, speed_i (held for whole pass). Mode transitions:
//   GROUP & split -> SPLIT, load per-sprite dirs from SPLIT_DIR; REGROUP & split -> SPLIT, reload;
//   SPLIT & !split -> REGROUP. GROUP: compute shared step from bbox (sprite 0 left, sprite N-1 right,
//   sprite 0 y).
//  Step rule (per axis, size S, limit L, spd): dir+: room = L-(p+S); step = min(spd, room);
//   flip to - if room<=spd. dir-: step = min(spd, p); flip to + if p<=spd. Never leaves [0, L-S].
//  GROUP: every sprite moves by the shared step; shared dirs flip per rule on bbox.
//  SPLIT: each sprite applies step rule with its own dirs.
//  REGROUP: each axis moves toward home by min(spd, |home-p|); after COMMIT, if all at home,
//   mode -> GROUP with group dirs reset to +x,+y.
//  speed 0: no motion, no direction flips; pass still runs and pulses frame_done_o.
//  Arithmetic 12-bit unsigned, compare in 13 bits; no wrap.
//  COMMIT: copy working regs to pos_x_o/pos_y_o/mode_o in one edge (no tearing mid-pass).
// TESTING
//  Reset -> pos_x_o = {1350,1100,850,600}, pos_y_o all 450, mode_o 0, busy_o 0, done 0.
//  GROUP, speed 3, one VSync fall -> outputs x+3, y+3 exactly 6 enabled cycles later, done 1 cycle.
//  GROUP, sprite3 x=1717 -> x=1720, xdir flips; next frame 1717; no sprite exceeds 1720.
//  split_i=1 tick -> mode 1, sprite0 x-3,y+3, sprite3 x+3,y+3; then split_i=0 -> REGROUP,
//   sprite 2px from home moves 2, mode 0 on pass all home.
//  Second VSync fall 3 cycles after first -> ignored, overrun_o=1, pass result unchanged.
//  cen_i low 10 cycles mid-UPDATE -> state frozen; final outputs identical to uninterrupted run.

Source files
------------

// File: rtl/sprite_motion_sched.sv
// rtl/sprite_motion_sched.sv - per-frame sprite motion scheduler with group/split/regroup modes
// One shared step/bounce unit is time-multiplexed over the sprites; results commit atomically.
module sprite_motion_sched #(
  parameter int                  N_SPR     = 4,
  parameter int                  SPR_W     = 200,
  parameter int                  SPR_H     = 250,
  parameter int                  X_MAX     = 1920,
  parameter int                  Y_MAX     = 1080,
  parameter logic [12*N_SPR-1:0] HOME_X    = {12'd1350, 12'd1100, 12'd850, 12'd600},
  parameter logic [12*N_SPR-1:0] HOME_Y    = {4{12'd450}},
  parameter logic [2*N_SPR-1:0]  SPLIT_DIR = 8'b11_01_00_10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cen_i,
  input  logic [3:0]           fvht_i,
  input  logic                 split_i,
  input  logic [3:0]           speed_i,
  output logic [12*N_SPR-1:0]  pos_x_o,
  output logic [12*N_SPR-1:0]  pos_y_o,
  output logic [1:0]           mode_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 overrun_o
);
  localparam int          IW   = $clog2(N_SPR);
  localparam logic [12:0] W13  = 13'(SPR_W);
  localparam logic [12:0] H13  = 13'(SPR_H);
  localparam logic [12:0] XL13 = 13'(X_MAX);
  localparam logic [12:0] YL13 = 13'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_UPDATE, S_COMMIT} state_t;
  typedef enum logic [1:0] {M_GROUP = 2'd0, M_SPLIT = 2'd1, M_REGROUP = 2'd2} mode_t;

  state_t              r_state;
  mode_t               r_mode, r_mode_o;
  logic [IW-1:0]       r_idx;
  logic [11:0]         r_x [N_SPR];
  logic [11:0]         r_y [N_SPR];
  logic [12*N_SPR-1:0] r_pos_x, r_pos_y;
  logic [N_SPR-1:0]    r_dx, r_dy;
  logic                r_gdx, r_gdy, r_pdx, r_pdy;
  logic [3:0]          r_spd, r_sx, r_sy;
  logic                r_vs, r_busy, r_done, r_ovr;

  logic        w_tick, w_dx, w_dy, w_all_home, w_unused;
  logic [11:0] w_px, w_py, w_hx, w_hy, w_gxd, w_gyd, w_gxs, w_gys;
  logic [3:0]  w_spd;
  logic [4:0]  w_rx, w_ry;

  // Returns {flip, step}: room toward the travel edge, clipped to spd; flip when the edge is reached.
  function automatic logic [4:0] step_rule(input logic [11:0] p, input logic dir,
                                           input logic [12:0] size, input logic [12:0] lim,
                                           input logic [3:0] spd);
    logic [12:0] room, s13, avail;
    s13 = {9'd0, spd};
    if (dir) room = (lim > {1'b0, p} + size) ? lim - {1'b0, p} - size : 13'd0;
    else     room = {1'b0, p};
    avail = (s13 < room) ? s13 : room;
    return {(spd != 4'd0) && (room <= s13), avail[3:0]};
  endfunction

  assign w_tick   = cen_i & ~fvht_i[2] & r_vs;
  assign w_unused = ^{fvht_i[3], fvht_i[1:0]};

  // In PREP the unit sees the group bounding box; in UPDATE it sees the indexed sprite.
  always_comb begin
    w_px  = r_x[r_idx];
    w_py  = r_y[r_idx];
    w_dx  = r_dx[r_idx];
    w_dy  = r_dy[r_idx];
    w_spd = r_spd;
    if (r_state == S_PREP) begin
      w_px  = r_gdx ? r_x[N_SPR-1] : r_x[0];
      w_py  = r_y[0];
      w_dx  = r_gdx;
      w_dy  = r_gdy;
      w_spd = speed_i;
    end
  end

  assign w_rx  = step_rule(w_px, w_dx, W13, XL13, w_spd);
  assign w_ry  = step_rule(w_py, w_dy, H13, YL13, w_spd);
  assign w_hx  = HOME_X[12*int'(r_idx) +: 12];
  assign w_hy  = HOME_Y[12*int'(r_idx) +: 12];
  assign w_gxd = (w_hx > w_px) ? w_hx - w_px : w_px - w_hx;
  assign w_gyd = (w_hy > w_py) ? w_hy - w_py : w_py - w_hy;
  assign w_gxs = (w_gxd < {8'd0, r_spd}) ? w_gxd : {8'd0, r_spd};
  assign w_gys = (w_gyd < {8'd0, r_spd}) ? w_gyd : {8'd0, r_spd};

  always_comb begin
    w_all_home = 1'b1;
    for (int i = 0; i < N_SPR; i++)
      if (r_x[i] != HOME_X[12*i +: 12] || r_y[i] != HOME_Y[12*i +: 12]) w_all_home = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_SPR; i++) begin
        r_x[i] <= HOME_X[12*i +: 12];
        r_y[i] <= HOME_Y[12*i +: 12];
      end
      r_pos_x  <= HOME_X;
      r_pos_y  <= HOME_Y;
      r_mode   <= M_GROUP;
      r_mode_o <= M_GROUP;
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_gdx    <= 1'b1;
      r_gdy    <= 1'b1;
      r_pdx    <= 1'b1;
      r_pdy    <= 1'b1;
      r_spd    <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_vs     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else if (cen_i) begin
      r_vs   <= fvht_i[2];
      r_done <= 1'b0;
      if (w_tick && r_state != S_IDLE) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: if (w_tick) begin
          r_state <= S_PREP;
          r_busy  <= 1'b1;
        end
        S_PREP: begin
          r_spd   <= speed_i;
          r_idx   <= '0;
          r_state <= S_UPDATE;
          r_pdx   <= r_gdx;
          r_pdy   <= r_gdy;
          r_sx    <= w_rx[3:0];
          r_sy    <= w_ry[3:0];
          if (split_i && r_mode != M_SPLIT) begin
            r_mode <= M_SPLIT;
            for (int i = 0; i < N_SPR; i++) begin
              r_dx[i] <= SPLIT_DIR[2*i];
              r_dy[i] <= SPLIT_DIR[2*i+1];
            end
          end else if (!split_i && r_mode == M_SPLIT) begin
            r_mode <= M_REGROUP;
          end else if (r_mode == M_GROUP) begin
            if (w_rx[4]) r_gdx <= ~r_gdx;
            if (w_ry[4]) r_gdy <= ~r_gdy;
          end
        end
        S_UPDATE: begin
          case (r_mode)
            M_GROUP: begin
              r_x[r_idx] <= r_pdx ? w_px + {8'd0, r_sx} : w_px - {8'd0, r_sx};
              r_y[r_idx] <= r_pdy ? w_py + {8'd0, r_sy} : w_py - {8'd0, r_sy};
            end
            M_SPLIT: begin
              r_x[r_idx] <= w_dx ? w_px + {8'd0, w_rx[3:0]} : w_px - {8'd0, w_rx[3:0]};
              r_y[r_idx] <= w_dy ? w_py + {8'd0, w_ry[3:0]} : w_py - {8'd0, w_ry[3:0]};
              if (w_rx[4]) r_dx[r_idx] <= ~w_dx;
              if (w_ry[4]) r_dy[r_idx] <= ~w_dy;
            end
            default: begin
              r_x[r_idx] <= (w_hx > w_px) ? w_px + w_gxs : w_px - w_gxs;
              r_y[r_idx] <= (w_hy > w_py) ? w_py + w_gys : w_py - w_gys;
            end
          endcase
          if (r_idx == IW'(N_SPR - 1)) r_state <= S_COMMIT;
          else                         r_idx   <= r_idx + 1'b1;
        end
        default: begin
          for (int i = 0; i < N_SPR; i++) begin
            r_pos_x[12*i +: 12] <= r_x[i];
            r_pos_y[12*i +: 12] <= r_y[i];
          end
          if (r_mode == M_REGROUP && w_all_home) begin
            r_mode   <= M_GROUP;
            r_mode_o <= M_GROUP;
            r_gdx    <= 1'b1;
            r_gdy    <= 1'b1;
          end else begin
            r_mode_o <= r_mode;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pos_x_o      = r_pos_x;
  assign pos_y_o      = r_pos_y;
  assign mode_o       = r_mode_o;
  assign busy_o       = r_busy;
  assign frame_done_o = r_done;
  assign overrun_o    = r_ovr;
endmodule

// File: tb/tb_sprite_motion_sched.sv
// tb/tb_sprite_motion_sched.sv - randomized self-checking bench for sprite_motion_sched
module tb_sprite_motion_sched;
  localparam int N  = 4;
  localparam int SW = 200;
  localparam int SH = 250;
  localparam int XM = 1920;
  localparam int YM = 1080;

  logic        clk_i = 1'b0;
  logic        rst_i, cen_i, split_i;
  logic [3:0]  fvht_i, speed_i;
  logic [47:0] pos_x_o, pos_y_o;
  logic [1:0]  mode_o;
  logic        busy_o, frame_done_o, overrun_o;

  int n_checks = 0;
  int n_errors = 0;

  int home_x[N]   = '{600, 850, 1100, 1350};
  int home_y[N]   = '{450, 450, 450, 450};
  bit split_dx[N] = '{0, 0, 1, 1};
  bit split_dy[N] = '{1, 0, 0, 1};

  int m_x[N], m_y[N], m_mode;
  bit m_gdx, m_gdy;
  bit m_dx[N], m_dy[N];

  sprite_motion_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .fvht_i(fvht_i),
    .split_i(split_i), .speed_i(speed_i), .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
    .mode_o(mode_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = home_x[i]; m_y[i] = home_y[i]; m_dx[i] = 0; m_dy[i] = 0;
    end
    m_mode = 0; m_gdx = 1; m_gdy = 1;
  endfunction

  function automatic void axis(input int p, input bit d, input int sz, input int lim,
                               input int spd, output int np, output bit nd);
    int room;
    room = d ? lim - (p + sz) : p;
    np   = d ? p + min2(spd, room) : p - min2(spd, room);
    nd   = (spd > 0 && room <= spd) ? !d : d;
  endfunction

  function automatic int toward(int p, int h, int spd);
    int st = min2(spd, (h > p) ? h - p : p - h);
    return (h > p) ? p + st : p - st;
  endfunction

  // One whole frame of motion computed directly from the movement rules.
  function automatic void model_pass(input bit sp, input int spd);
    int np, dxs, dys;
    bit nd, home;
    if (sp && m_mode != 1) begin
      m_mode = 1;
      for (int i = 0; i < N; i++) begin m_dx[i] = split_dx[i]; m_dy[i] = split_dy[i]; end
    end else if (!sp && m_mode == 1) m_mode = 2;
    if (m_mode == 0) begin
      if (m_gdx) begin axis(m_x[N-1], 1, SW, XM, spd, np, nd); dxs = np - m_x[N-1]; end
      else       begin axis(m_x[0],   0, SW, XM, spd, np, nd); dxs = np - m_x[0];   end
      m_gdx = nd;
      axis(m_y[0], m_gdy, SH, YM, spd, np, nd);
      dys = np - m_y[0];
      m_gdy = nd;
      for (int i = 0; i < N; i++) begin m_x[i] += dxs; m_y[i] += dys; end
    end else if (m_mode == 1) begin
      for (int i = 0; i < N; i++) begin
        axis(m_x[i], m_dx[i], SW, XM, spd, np, nd); m_x[i] = np; m_dx[i] = nd;
        axis(m_y[i], m_dy[i], SH, YM, spd, np, nd); m_y[i] = np; m_dy[i] = nd;
      end
    end else begin
      home = 1;
      for (int i = 0; i < N; i++) begin
        m_x[i] = toward(m_x[i], home_x[i], spd);
        m_y[i] = toward(m_y[i], home_y[i], spd);
        if (m_x[i] != home_x[i] || m_y[i] != home_y[i]) home = 0;
      end
      if (home) begin m_mode = 0; m_gdx = 1; m_gdy = 1; end
    end
  endfunction

  function automatic logic [47:0] exp_x();
    logic [47:0] v;
    for (int i = 0; i < N; i++) v[12*i +: 12] = 12'(m_x[i]);
    return v;
  endfunction

  function automatic logic [47:0] exp_y();
    logic [47:0] v;
    for (int i = 0; i < N; i++) v[12*i +: 12] = 12'(m_y[i]);
    return v;
  endfunction

  task automatic do_reset();
    rst_i = 1; cen_i = 1; split_i = 0; speed_i = 0; fvht_i = 4'b0100;
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    model_reset();
  endtask

  task automatic run_frame(input bit sp, input logic [3:0] spd, input bit jitter, output bit ok);
    split_i = sp; speed_i = spd; cen_i = 1;
    fvht_i = (4'($urandom) & 4'b1011) | 4'b0100;
    @(negedge clk_i);
    fvht_i = 4'($urandom) & 4'b1011;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      if (frame_done_o) ok = 1;
      else if (jitter) cen_i = ($urandom_range(0, 3) != 0);
    end
    cen_i = 1; fvht_i = 4'b0100;
    model_pass(sp, int'(spd));
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pos_x_o !== 48'h546_44C_352_258) begin n_errors++; $display("FAIL reset_x got %h want 546_44c_352_258", pos_x_o); end
    n_checks++; if (pos_y_o !== {4{12'd450}}) begin n_errors++; $display("FAIL reset_y got %h", pos_y_o); end
    n_checks++; if (mode_o !== 2'd0) begin n_errors++; $display("FAIL reset_mode got %0d want 0", mode_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++; if (frame_done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", frame_done_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got %b want 0", overrun_o); end
  endtask

  task automatic test_group_latency();
    logic [47:0] old_x;
    do_reset();
    old_x = exp_x();
    split_i = 0; speed_i = 3; fvht_i = 4'b0100;
    @(negedge clk_i);
    fvht_i = 4'b0000;
    model_pass(0, 3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL lat_busy got %b want 1", busy_o); end
      end
      if (k <= 6) begin
        n_checks++;
        if (pos_x_o !== old_x || frame_done_o !== 1'b0) begin
          n_errors++; $display("FAIL lat_early k=%0d x=%h done=%b want x=%h done=0", k, pos_x_o, frame_done_o, old_x);
        end
      end else if (k == 7) begin
        n_checks++; if (pos_x_o !== exp_x()) begin n_errors++; $display("FAIL lat_x got %h want %h", pos_x_o, exp_x()); end
        n_checks++; if (pos_y_o !== exp_y()) begin n_errors++; $display("FAIL lat_y got %h want %h", pos_y_o, exp_y()); end
        n_checks++; if (frame_done_o !== 1'b1) begin n_errors++; $display("FAIL lat_done got %b want 1", frame_done_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL lat_busy_end got %b want 0", busy_o); end
      end else begin
        n_checks++; if (frame_done_o !== 1'b0) begin n_errors++; $display("FAIL lat_pulse got %b want 0", frame_done_o); end
      end
    end
    n_checks++; if (pos_x_o[47:36] !== 12'd1353) begin n_errors++; $display("FAIL lat_x3 got %0d want 1353", pos_x_o[47:36]); end
    fvht_i = 4'b0100;
  endtask

  task automatic test_group_bounce();
    bit ok;
    logic [3:0] spd;
    do_reset();
    for (int f = 0; f < 27; f++) begin
      spd = (f < 24) ? 4'd15 : (f == 24) ? 4'd7 : 4'd3;
      run_frame(0, spd, 0, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL bounce_timeout frame %0d", f); end
      n_checks++; if (pos_x_o !== exp_x()) begin n_errors++; $display("FAIL bounce_x f=%0d got %h want %h", f, pos_x_o, exp_x()); end
      n_checks++; if (pos_y_o !== exp_y()) begin n_errors++; $display("FAIL bounce_y f=%0d got %h want %h", f, pos_y_o, exp_y()); end
      for (int i = 0; i < N; i++) begin
        n_checks++; if (pos_x_o[12*i +: 12] > 12'd1720) begin n_errors++; $display("FAIL bounce_bound s%0d got %0d max 1720", i, pos_x_o[12*i +: 12]); end
      end
      if (f == 25) begin
        n_checks++; if (pos_x_o[47:36] !== 12'd1720) begin n_errors++; $display("FAIL bounce_edge got %0d want 1720", pos_x_o[47:36]); end
      end
      if (f == 26) begin
        n_checks++; if (pos_x_o[47:36] !== 12'd1717) begin n_errors++; $display("FAIL bounce_back got %0d want 1717", pos_x_o[47:36]); end
      end
    end
  endtask

  task automatic test_split_regroup();
    bit ok;
    int nf;
    do_reset();
    run_frame(1, 3, 0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL split_timeout"); end
    n_checks++; if (mode_o !== 2'd1) begin n_errors++; $display("FAIL split_mode got %0d want 1", mode_o); end
    n_checks++; if (pos_x_o[11:0] !== 12'd597 || pos_y_o[11:0] !== 12'd453) begin n_errors++; $display("FAIL split_s0 got %0d,%0d want 597,453", pos_x_o[11:0], pos_y_o[11:0]); end
    n_checks++; if (pos_x_o[47:36] !== 12'd1353 || pos_y_o[47:36] !== 12'd453) begin n_errors++; $display("FAIL split_s3 got %0d,%0d want 1353,453", pos_x_o[47:36], pos_y_o[47:36]); end
    n_checks++; if (pos_x_o !== exp_x() || pos_y_o !== exp_y()) begin n_errors++; $display("FAIL split_all got %h/%h want %h/%h", pos_x_o, pos_y_o, exp_x(), exp_y()); end

    do_reset();
    run_frame(1, 1, 0, ok);
    run_frame(1, 1, 0, ok);
    run_frame(0, 3, 0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL regroup_timeout"); end
    n_checks++; if (pos_x_o !== 48'h546_44C_352_258 || pos_y_o !== {4{12'd450}}) begin n_errors++; $display("FAIL regroup_home got %h/%h", pos_x_o, pos_y_o); end
    n_checks++; if (mode_o !== 2'd0) begin n_errors++; $display("FAIL regroup_mode got %0d want 0", mode_o); end

    do_reset();
    nf = $urandom_range(2, 6);
    for (int f = 0; f < nf + 40; f++) begin
      if (f >= nf && m_mode == 0) break;
      run_frame(f < nf, (f < nf) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15)), 1, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL srr_timeout f=%0d", f); end
      n_checks++; if (mode_o !== 2'(m_mode)) begin n_errors++; $display("FAIL srr_mode f=%0d got %0d want %0d", f, mode_o, m_mode); end
      n_checks++; if (pos_x_o !== exp_x() || pos_y_o !== exp_y()) begin n_errors++; $display("FAIL srr_pos f=%0d got %h/%h want %h/%h", f, pos_x_o, pos_y_o, exp_x(), exp_y()); end
    end
  endtask

  task automatic test_overrun();
    int extra;
    bit ok;
    do_reset();
    split_i = 0; speed_i = 4; fvht_i = 4'b0100;
    @(negedge clk_i);
    fvht_i = 4'b0000;
    @(negedge clk_i); fvht_i = 4'b0100;
    @(negedge clk_i);
    @(negedge clk_i); fvht_i = 4'b0000;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk_i);
      if (frame_done_o) ok = 1;
    end
    model_pass(0, 4);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL ovr_timeout"); end
    n_checks++; if (overrun_o !== 1'b1) begin n_errors++; $display("FAIL ovr_flag got %b want 1", overrun_o); end
    n_checks++; if (pos_x_o !== exp_x() || pos_y_o !== exp_y()) begin n_errors++; $display("FAIL ovr_pos got %h/%h want %h/%h", pos_x_o, pos_y_o, exp_x(), exp_y()); end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (frame_done_o) extra++;
    end
    n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL ovr_extra_pass got %0d want 0", extra); end
    n_checks++; if (overrun_o !== 1'b1 || pos_x_o !== exp_x()) begin n_errors++; $display("FAIL ovr_sticky got %b x=%h", overrun_o, pos_x_o); end
    do_reset();
    n_checks++; if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL ovr_clear got %b want 0", overrun_o); end
  endtask

  task automatic test_cen_stall();
    bit ok;
    logic [47:0] old_x, old_y;
    do_reset();
    run_frame(0, 5, 0, ok);
    old_x = exp_x(); old_y = exp_y();
    split_i = 1; speed_i = 9; fvht_i = 4'b0100;
    @(negedge clk_i);
    fvht_i = 4'b0000;
    repeat (3) @(negedge clk_i);
    cen_i = 0;
    for (int k = 0; k < 10; k++) begin
      fvht_i = 4'($urandom); split_i = 1'($urandom); speed_i = 4'($urandom);
      @(negedge clk_i);
    end
    n_checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin n_errors++; $display("FAIL stall_busy got busy=%b done=%b want 1,0", busy_o, frame_done_o); end
    n_checks++; if (pos_x_o !== old_x || pos_y_o !== old_y) begin n_errors++; $display("FAIL stall_pos got %h/%h want %h/%h", pos_x_o, pos_y_o, old_x, old_y); end
    fvht_i = 4'b0000;
    cen_i = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk_i);
      if (frame_done_o) ok = 1;
    end
    model_pass(1, 9);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_timeout"); end
    n_checks++; if (pos_x_o !== exp_x() || pos_y_o !== exp_y()) begin n_errors++; $display("FAIL stall_result got %h/%h want %h/%h", pos_x_o, pos_y_o, exp_x(), exp_y()); end
    n_checks++; if (mode_o !== 2'd1 || overrun_o !== 1'b0) begin n_errors++; $display("FAIL stall_mode got %0d ovr=%b want 1,0", mode_o, overrun_o); end
    split_i = 0; speed_i = 0; fvht_i = 4'b0100;
  endtask

  task automatic test_random();
    bit ok, sp;
    do_reset();
    sp = 0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 5) == 0) sp = !sp;
      run_frame(sp, 4'($urandom_range(0, 15)), 1, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL rnd_timeout f=%0d", f); end
      n_checks++; if (pos_x_o !== exp_x() || pos_y_o !== exp_y()) begin n_errors++; $display("FAIL rnd_pos f=%0d got %h/%h want %h/%h", f, pos_x_o, pos_y_o, exp_x(), exp_y()); end
      n_checks++; if (mode_o !== 2'(m_mode)) begin n_errors++; $display("FAIL rnd_mode f=%0d got %0d want %0d", f, mode_o, m_mode); end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (pos_x_o[12*i +: 12] > 12'(XM - SW) || pos_y_o[12*i +: 12] > 12'(YM - SH)) begin
          n_errors++; $display("FAIL rnd_bound s%0d got %0d,%0d", i, pos_x_o[12*i +: 12], pos_y_o[12*i +: 12]);
        end
      end
    end
    n_checks++; if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL rnd_overrun got %b want 0", overrun_o); end
  endtask

  initial begin
    test_reset();
    test_group_latency();
    test_group_bounce();
    test_split_regroup();
    test_overrun();
    test_cen_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
